// File: rtl/run_ctrl_pkg.sv
// Shared types and widths for the run controller.
package run_ctrl_pkg;

    localparam int unsigned COUNT_W = 32;
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter
    import run_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = COUNT_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Count up while enabled, stick at all-ones.
    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/run_controller.sv
// Run controller: stretched core reset (HOLD), counted run (RUN), sticky end (DONE).
// Build option: define RUN_CTRL_TIMEOUT_EN to end RUN on the MAX_CYCLES budget.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 10000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               halt_req,
    input  logic               restart,
    output logic               core_reset,
    output logic               running,
    output logic               done,
    output logic               timed_out,
    output logic [COUNT_W-1:0] cycle_count
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES);

    // Reject out-of-range configurations at elaboration.
    if (RESET_CYCLES == 0 || RESET_CYCLES > 255) begin : g_bad_reset_cycles
        $error("run_controller: RESET_CYCLES must be in 1..255");
    end
    if (MAX_CYCLES == 0) begin : g_bad_max_cycles
        $error("run_controller: MAX_CYCLES must be at least 1");
    end

    run_state_e        state;
    run_state_e        state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              timeout_hit;
    logic              count_clear;
    logic              count_enable;
    logic              core_reset_d;
    logic              running_d;
    logic              done_d;
    logic              timed_out_d;

    // Budget reached: this RUN cycle is the last one allowed.
`ifdef RUN_CTRL_TIMEOUT_EN
    localparam logic [COUNT_W-1:0] LAST_CYCLE = COUNT_W'(MAX_CYCLES - 1);
    assign timeout_hit = (cycle_count == LAST_CYCLE);
`else
    assign timeout_hit = 1'b0;
`endif

    // State register and HOLD countdown.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // Next-state logic; halt_req has priority over the budget in RUN.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        case (state)
            HOLD: begin
                if (hold_cnt <= HOLD_W'(1)) begin
                    state_next = RUN;
                end else begin
                    hold_cnt_next = hold_cnt - HOLD_W'(1);
                end
            end
            RUN: begin
                if (halt_req || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (restart) begin
                    state_next    = HOLD;
                    hold_cnt_next = HOLD_LOAD;
                end
            end
            default: begin
                state_next    = HOLD;
                hold_cnt_next = HOLD_LOAD;
            end
        endcase
    end

    // Next output values, decoded from the upcoming state.
    always_comb begin
        core_reset_d = (state_next == HOLD);
        running_d    = (state_next == RUN);
        done_d       = (state_next == DONE);
        timed_out_d  = 1'b0;
        if (state_next == DONE) begin
            timed_out_d = (state == RUN) ? (timeout_hit && !halt_req) : timed_out;
        end
    end

    // Output register; reset values match a fresh HOLD.
    always_ff @(posedge clock) begin
        if (reset) begin
            core_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            core_reset <= core_reset_d;
            running    <= running_d;
            done       <= done_d;
            timed_out  <= timed_out_d;
        end
    end

    // Run-cycle counter: counts every RUN cycle, including the one that ends the run.
    assign count_clear  = reset || ((state == DONE) && restart);
    assign count_enable = (state == RUN);

    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_cycle_counter (
        .clock  (clock),
        .clear  (count_clear),
        .enable (count_enable),
        .count  (cycle_count)
    );

endmodule

// File: tb/tb_run_controller.sv
// Randomized bench for run_controller against a cycle-level behavioural model.
module tb_run_controller;

    localparam int unsigned RC = 4;
    localparam int unsigned MC = 10;
`ifdef RUN_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        halt_req = 1'b0;
    logic        restart = 1'b0;
    logic        core_reset;
    logic        running;
    logic        done;
    logic        timed_out;
    logic [31:0] cycle_count;

    int errors = 0;
    int checks = 0;

    // Model: phase 0 = holding in reset, 1 = running, 2 = finished.
    int              m_phase;
    int              m_hold_left;
    longint unsigned m_count;
    bit              m_to;

    run_controller #(
        .RESET_CYCLES (RC),
        .MAX_CYCLES   (MC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .halt_req    (halt_req),
        .restart     (restart),
        .core_reset  (core_reset),
        .running     (running),
        .done        (done),
        .timed_out   (timed_out),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance the model by one rising edge with the given inputs.
    task automatic model_edge(input bit r, input bit h, input bit rs);
        longint unsigned nxt;
        if (r) begin
            m_phase = 0; m_hold_left = RC; m_count = 0; m_to = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_hold_left--;
                    if (m_hold_left == 0) begin
                        m_phase = 1;
                        m_count = 0;
                    end
                end
                1: begin
                    nxt = (m_count >= 64'hFFFF_FFFF) ? m_count : m_count + 1;
                    if (h) begin
                        m_phase = 2; m_to = 0;
                    end else if (TO_EN && m_count == MC - 1) begin
                        m_phase = 2; m_to = 1;
                    end
                    m_count = nxt;
                end
                default: begin
                    if (rs) begin
                        m_phase = 0; m_hold_left = RC; m_count = 0; m_to = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".core_reset"}, 32'(core_reset), 32'(m_phase == 0));
        check({tag, ".running"},    32'(running),    32'(m_phase == 1));
        check({tag, ".done"},       32'(done),       32'(m_phase == 2));
        check({tag, ".timed_out"},  32'(timed_out),  32'(m_to));
        check({tag, ".cycle_count"}, cycle_count,    m_count[31:0]);
    endtask

    // Drive inputs, take one edge, then compare on the falling edge.
    task automatic cycle(input bit r, input bit h, input bit rs, input string tag);
        reset = r; halt_req = h; restart = rs;
        @(posedge clock);
        model_edge(r, h, rs);
        @(negedge clock);
        check_outputs(tag);
    endtask

    // Idle until the model is in RUN with the given count, within a cycle budget.
    task automatic run_to_count(input longint unsigned target, input string tag);
        int guard;
        guard = 0;
        while (!(m_phase == 1 && m_count == target) && guard < 200) begin
            cycle(1'b0, 1'b0, 1'b0, tag);
            guard++;
        end
        if (guard >= 200) check({tag, ".wait_expired"}, 32'(guard), 32'd0);
    endtask

    initial begin
        m_phase = 0; m_hold_left = RC; m_count = 0; m_to = 0;
        @(negedge clock);

        // Reset release, then exactly RC cycles of core_reset before RUN.
        cycle(1'b1, 1'b0, 1'b0, "reset");
        cycle(1'b1, 1'b0, 1'b0, "reset");
        check("reset_core_reset", 32'(core_reset), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, "hold");
        check("hold_last_core_reset", 32'(core_reset), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, "first_run");
        check("first_run_running", 32'(running), 32'd1);
        check("first_run_count", cycle_count, 32'd0);

        // Halt on RUN cycle 5; later halts are ignored.
        run_to_count(5, "to_halt5");
        cycle(1'b0, 1'b1, 1'b0, "halt5");
        check("halt5_done", 32'(done), 32'd1);
        check("halt5_timed_out", 32'(timed_out), 32'd0);
        check("halt5_count", cycle_count, 32'd6);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, "done_halt");
        check("done_sticky_count", cycle_count, 32'd6);

        // Restart: fresh HOLD, then a run with no halt.
        cycle(1'b0, 1'b0, 1'b1, "restart");
        check("restart_core_reset", 32'(core_reset), 32'd1);
        check("restart_count", cycle_count, 32'd0);
        run_to_count(0, "restart_hold");
        check("fresh_run_timed_out", 32'(timed_out), 32'd0);
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 1'b0, "free_run");
        check("free_run_done", 32'(done), 32'(TO_EN));
        check("free_run_timed_out", 32'(timed_out), 32'(TO_EN));
        check("free_run_count", cycle_count, TO_EN ? 32'd10 : 32'd50);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, "free_hold");

        // Halt coinciding with the last budget cycle.
        cycle(1'b1, 1'b0, 1'b0, "reset2");
        run_to_count(9, "to_nine");
        cycle(1'b0, 1'b1, 1'b0, "halt9");
        check("halt9_done", 32'(done), 32'd1);
        check("halt9_timed_out", 32'(timed_out), 32'd0);
        check("halt9_count", cycle_count, 32'd10);

        // Reset beats restart in DONE.
        cycle(1'b1, 1'b0, 1'b1, "reset_vs_restart");

        // Reset in the middle of a run.
        run_to_count(3, "to_three");
        cycle(1'b1, 1'b1, 1'b0, "mid_run_reset");
        check("mid_run_reset_core_reset", 32'(core_reset), 32'd1);
        check("mid_run_reset_count", cycle_count, 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 99) == 0),
                  1'($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 2) == 0),
                  "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 4: cycles core_reset is held after reset or restart; legal 1..255.
REQ-002 SHALL have parameter MAX_CYCLES, default 10000: RUN-cycle budget before timeout; legal 1..2^32-1.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port halt_req  input  1  DUT-side request to end the run; level-sampled.
REQ-006 SHALL have port restart  input  1  single-cycle pulse that leaves DONE and begins a new run.
REQ-007 SHALL have port core_reset  output  1  stretched synchronous active-high reset for the design under control.
REQ-008 SHALL have port running  output  1  high only in RUN.
REQ-009 SHALL have port done  output  1  high only in DONE.
REQ-010 SHALL have port timed_out  output  1  high in DONE when the run ended on the cycle budget.
REQ-011 SHALL have port cycle_count  output  32  number of RUN cycles completed in the current or last run.

Function
REQ-012 SHALL implement a three-state FSM: HOLD, RUN, DONE.
REQ-013 HOLD SHALL assert core_reset and count down from RESET_CYCLES; it SHALL enter RUN after exactly RESET_CYCLES cycles in HOLD.
REQ-014 On HOLD->RUN, core_reset SHALL fall, and cycle_count SHALL be 0 in the first RUN cycle.
REQ-015 In RUN, cycle_count SHALL increment by 1 each cycle and saturate at 2^32-1 without wrapping.
REQ-016 In RUN, halt_req high SHALL move the FSM to DONE on the next edge with timed_out=0; cycle_count SHALL freeze at its value including the halting cycle.
REQ-017 In RUN, when cycle_count reaches MAX_CYCLES-1 and halt_req is low, the FSM SHALL move to DONE on the next edge with timed_out=1.
REQ-018 When halt_req and timeout coincide in the same cycle, halt_req SHALL win and timed_out SHALL be 0.
REQ-019 DONE SHALL be sticky; halt_req SHALL be ignored in DONE.
REQ-020 restart in DONE SHALL enter HOLD, clear timed_out, and clear cycle_count; restart SHALL be ignored in HOLD and RUN.
REQ-021 Outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-022 reset SHALL force HOLD with the countdown reloaded, core_reset=1, running=0, done=0, timed_out=0, cycle_count=0, regardless of current state, including mid-HOLD and mid-RUN.
REQ-023 reset SHALL take priority over halt_req and restart in the same cycle.

Configuration
REQ-024 Macro RUN_CTRL_TIMEOUT_EN SHALL select whether the budget check is built.
REQ-025 With RUN_CTRL_TIMEOUT_EN defined, REQ-017 and REQ-018 SHALL apply.
REQ-026 Without RUN_CTRL_TIMEOUT_EN, MAX_CYCLES SHALL be unused, RUN SHALL end only on halt_req, and timed_out SHALL be tied to 0.

Structure
REQ-027 Package run_ctrl_pkg SHALL hold the FSM state enum (HOLD, RUN, DONE) and the 32-bit count width constant.
REQ-028 Sub-module sat_counter (32-bit, enable, clear, saturating) SHALL implement cycle_count; the HOLD countdown SHALL remain inline.

Verification
REQ-029 Reset, then release with halt_req=0 and RESET_CYCLES=4 -> core_reset high for 4 cycles after reset falls, then running=1 with cycle_count=0.
REQ-030 MAX_CYCLES=10, macro defined, no halt_req -> done=1 and timed_out=1 with cycle_count=10; state held for 20 further cycles.
REQ-031 halt_req pulse on RUN cycle 5 -> done=1 and timed_out=0 with cycle_count=6; later halt_req pulses have no effect.
REQ-032 MAX_CYCLES=10, halt_req high exactly on cycle_count=9 -> done=1 and timed_out=0.
REQ-033 restart pulse in DONE -> core_reset high for RESET_CYCLES, then a fresh RUN with cycle_count=0 and timed_out=0.
REQ-034 reset asserted on RUN cycle 3 -> next cycle in HOLD with core_reset=1 and cycle_count=0; macro undefined with MAX_CYCLES=10 -> still running after 50 cycles.
